// File: rtl/midi_message_decoder.sv
// midi_message_decoder
// Turns the MIDI receiver byte stream into note and control-change events.
// Handles running status, real-time bytes interleaved anywhere, SysEx /
// system-common cancellation and optional channel filtering. Events are
// one-cycle strobes; their payloads are held until the next event.

module midi_message_decoder #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_on,
  output logic [6:0] note_number,
  output logic [6:0] note_velocity,
  output logic [3:0] note_channel,
  output logic       note_ready,
  output logic [6:0] cc_number,
  output logic [6:0] cc_value,
  output logic       cc_ready,
  output logic [7:0] stray_count
);

  // IDLE also encodes "running status invalid".
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA1 = 2'd1,
    ST_DATA2 = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RT     = 3'd1,
    CLS_SYS    = 3'd2,
    CLS_STATUS = 3'd3,
    CLS_DATA   = 3'd4
  } byte_class_e;

  state_e      state_q, state_d;
  logic [3:0]  type_q, type_d;
  logic [3:0]  chan_q, chan_d;
  logic [6:0]  d1_q, d1_d;

  logic        note_on_q, note_on_d;
  logic [6:0]  note_number_q, note_number_d;
  logic [6:0]  note_velocity_q, note_velocity_d;
  logic [3:0]  note_channel_q, note_channel_d;
  logic        note_ready_q, note_ready_d;
  logic [6:0]  cc_number_q, cc_number_d;
  logic [6:0]  cc_value_q, cc_value_d;
  logic        cc_ready_q, cc_ready_d;
  logic [7:0]  stray_count_q, stray_count_d;

  byte_class_e byte_class_s;
  logic        chan_pass_s;
  logic        two_byte_s;

  // Classify the incoming byte; nothing is classified without a strobe.
  always_comb begin
    byte_class_s = CLS_NONE;
    if (!rx_valid) begin
      byte_class_s = CLS_NONE;
    end else if (rx_data[7:3] == 5'b11111) begin
      byte_class_s = CLS_RT;
    end else if (rx_data[7:3] == 5'b11110) begin
      byte_class_s = CLS_SYS;
    end else if (rx_data[7] == 1'b1) begin
      byte_class_s = CLS_STATUS;
    end else begin
      byte_class_s = CLS_DATA;
    end
  end

  assign chan_pass_s = (OMNI != 1'b0) || (chan_q == CHANNEL);
  // Program change (C) and channel pressure (D) carry a single data byte.
  assign two_byte_s  = (type_q != 4'hC) && (type_q != 4'hD);

  // Next-state, event and counter logic for one received byte.
  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    chan_d          = chan_q;
    d1_d            = d1_q;
    note_on_d       = note_on_q;
    note_number_d   = note_number_q;
    note_velocity_d = note_velocity_q;
    note_channel_d  = note_channel_q;
    note_ready_d    = 1'b0;
    cc_number_d     = cc_number_q;
    cc_value_d      = cc_value_q;
    cc_ready_d      = 1'b0;
    stray_count_d   = stray_count_q;

    case (byte_class_s)
      CLS_STATUS: begin
        // A new status preempts any unfinished message.
        type_d  = rx_data[7:4];
        chan_d  = rx_data[3:0];
        state_d = ST_DATA1;
      end
      CLS_SYS: begin
        state_d = ST_IDLE;
      end
      CLS_DATA: begin
        case (state_q)
          ST_IDLE: begin
            if (stray_count_q != 8'hFF) begin
              stray_count_d = stray_count_q + 8'd1;
            end else begin
              stray_count_d = stray_count_q;
            end
          end
          ST_DATA1: begin
            d1_d = rx_data[6:0];
            if (two_byte_s) begin
              state_d = ST_DATA2;
            end else begin
              state_d = ST_DATA1;
            end
          end
          ST_DATA2: begin
            // Message complete; return to DATA1 to keep running status.
            state_d = ST_DATA1;
            if (chan_pass_s) begin
              case (type_q)
                4'h8, 4'h9: begin
                  note_on_d       = (type_q == 4'h9) && (rx_data[6:0] != 7'd0);
                  note_number_d   = d1_q;
                  note_velocity_d = rx_data[6:0];
                  note_channel_d  = chan_q;
                  note_ready_d    = 1'b1;
                end
                4'hB: begin
                  cc_number_d = d1_q;
                  cc_value_d  = rx_data[6:0];
                  cc_ready_d  = 1'b1;
                end
                default: begin
                  // Aftertouch and pitch bend are parsed but not emitted.
                end
              endcase
            end else begin
              note_ready_d = 1'b0;
              cc_ready_d   = 1'b0;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      default: begin
        // No strobe or real-time byte: nothing changes.
      end
    endcase
  end

  // State, running-status and output registers.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q         <= ST_IDLE;
      type_q          <= 4'd0;
      chan_q          <= 4'd0;
      d1_q            <= 7'd0;
      note_on_q       <= 1'b0;
      note_number_q   <= 7'd0;
      note_velocity_q <= 7'd0;
      note_channel_q  <= 4'd0;
      note_ready_q    <= 1'b0;
      cc_number_q     <= 7'd0;
      cc_value_q      <= 7'd0;
      cc_ready_q      <= 1'b0;
      stray_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      type_q          <= type_d;
      chan_q          <= chan_d;
      d1_q            <= d1_d;
      note_on_q       <= note_on_d;
      note_number_q   <= note_number_d;
      note_velocity_q <= note_velocity_d;
      note_channel_q  <= note_channel_d;
      note_ready_q    <= note_ready_d;
      cc_number_q     <= cc_number_d;
      cc_value_q      <= cc_value_d;
      cc_ready_q      <= cc_ready_d;
      stray_count_q   <= stray_count_d;
    end
  end

  assign note_on       = note_on_q;
  assign note_number   = note_number_q;
  assign note_velocity = note_velocity_q;
  assign note_channel  = note_channel_q;
  assign note_ready    = note_ready_q;
  assign cc_number     = cc_number_q;
  assign cc_value      = cc_value_q;
  assign cc_ready      = cc_ready_q;
  assign stray_count   = stray_count_q;

endmodule

// File: tb/tb_midi_message_decoder.sv
// Bench for midi_message_decoder: an omni instance and a channel-2 filtered
// instance share one byte stream and are checked against a message-level
// reference model every cycle.

module tb_midi_message_decoder;

  logic       clk;
  logic       reset_l;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       o_non, o_nrdy, o_ccr;
  logic [6:0] o_num, o_vel, o_ccn, o_ccv;
  logic [3:0] o_ch;
  logic [7:0] o_stray;

  logic       f_non, f_nrdy, f_ccr;
  logic [6:0] f_num, f_vel, f_ccn, f_ccv;
  logic [3:0] f_ch;
  logic [7:0] f_stray;

  int n_cmp = 0;
  int n_err = 0;

  midi_message_decoder #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_omni (
    .clock_50_000_000(clk), .reset_l(reset_l), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(o_non), .note_number(o_num), .note_velocity(o_vel), .note_channel(o_ch),
    .note_ready(o_nrdy), .cc_number(o_ccn), .cc_value(o_ccv), .cc_ready(o_ccr),
    .stray_count(o_stray)
  );

  midi_message_decoder #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_filt (
    .clock_50_000_000(clk), .reset_l(reset_l), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(f_non), .note_number(f_num), .note_velocity(f_vel), .note_channel(f_ch),
    .note_ready(f_nrdy), .cc_number(f_ccn), .cc_value(f_ccv), .cc_ready(f_ccr),
    .stray_count(f_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (message level) ----------------
  logic       m_rs_valid;
  logic [7:0] m_rs;
  logic [6:0] m_data[$];
  int         m_stray;

  logic       e_non[2], e_nrdy[2], e_ccr[2];
  logic [6:0] e_num[2], e_vel[2], e_ccn[2], e_ccv[2];
  logic [3:0] e_ch[2];

  task automatic model_reset();
    m_rs_valid = 1'b0;
    m_rs       = 8'h00;
    m_data.delete();
    m_stray    = 0;
    for (int i = 0; i < 2; i++) begin
      e_non[i] = 1'b0; e_nrdy[i] = 1'b0; e_ccr[i] = 1'b0;
      e_num[i] = 7'd0; e_vel[i] = 7'd0; e_ccn[i] = 7'd0; e_ccv[i] = 7'd0;
      e_ch[i]  = 4'd0;
    end
  endtask

  // Instance 0 accepts every channel, instance 1 only channel 2.
  task automatic model_emit();
    logic [3:0] kind;
    logic [3:0] ch;
    kind = m_rs[7:4];
    ch   = m_rs[3:0];
    for (int i = 0; i < 2; i++) begin
      if (i == 0 || ch == 4'd2) begin
        if (kind == 4'h8 || kind == 4'h9) begin
          e_nrdy[i] = 1'b1;
          e_non[i]  = (kind == 4'h9) && (m_data[1] != 7'd0);
          e_num[i]  = m_data[0];
          e_vel[i]  = m_data[1];
          e_ch[i]   = ch;
        end else if (kind == 4'hB) begin
          e_ccr[i] = 1'b1;
          e_ccn[i] = m_data[0];
          e_ccv[i] = m_data[1];
        end
      end
    end
  endtask

  task automatic model_byte(input logic v, input logic [7:0] d);
    int need;
    for (int i = 0; i < 2; i++) begin
      e_nrdy[i] = 1'b0;
      e_ccr[i]  = 1'b0;
    end
    if (!v) return;
    if (d >= 8'hF8) return;
    if (d >= 8'hF0) begin
      m_rs_valid = 1'b0;
      m_data.delete();
    end else if (d >= 8'h80) begin
      m_rs_valid = 1'b1;
      m_rs       = d;
      m_data.delete();
    end else if (!m_rs_valid) begin
      if (m_stray < 255) m_stray++;
    end else begin
      m_data.push_back(d[6:0]);
      need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
      if (m_data.size() == need) begin
        model_emit();
        m_data.delete();
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_dut(input string pfx, input int i,
                             input logic non, input logic [6:0] num, input logic [6:0] vel,
                             input logic [3:0] ch, input logic nrdy, input logic [6:0] ccn,
                             input logic [6:0] ccv, input logic ccr, input logic [7:0] stray);
    check_val({pfx, "note_ready"},    32'(nrdy),  32'(e_nrdy[i]));
    check_val({pfx, "note_on"},       32'(non),   32'(e_non[i]));
    check_val({pfx, "note_number"},   32'(num),   32'(e_num[i]));
    check_val({pfx, "note_velocity"}, 32'(vel),   32'(e_vel[i]));
    check_val({pfx, "note_channel"},  32'(ch),    32'(e_ch[i]));
    check_val({pfx, "cc_ready"},      32'(ccr),   32'(e_ccr[i]));
    check_val({pfx, "cc_number"},     32'(ccn),   32'(e_ccn[i]));
    check_val({pfx, "cc_value"},      32'(ccv),   32'(e_ccv[i]));
    check_val({pfx, "stray_count"},   32'(stray), 32'(m_stray));
  endtask

  task automatic compare_all();
    compare_dut("omni.", 0, o_non, o_num, o_vel, o_ch, o_nrdy, o_ccn, o_ccv, o_ccr, o_stray);
    compare_dut("filt.", 1, f_non, f_num, f_vel, f_ch, f_nrdy, f_ccn, f_ccv, f_ccr, f_stray);
  endtask

  // Present one input cycle; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    model_byte(v, d);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask

  // Reset pulse asserted between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    #2;
    reset_l = 1'b0;
    #1;
    model_reset();
    compare_all();
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [3:0] kinds [8];
    kinds = '{4'h8, 4'h9, 4'h9, 4'hB, 4'hA, 4'hC, 4'hD, 4'hE};
    r = $urandom_range(0, 99);
    if (r < 20) return {kinds[$urandom_range(0, 7)], 4'($urandom_range(0, 3))};
    else if (r < 25) return 8'hF0 + 8'($urandom_range(0, 7));
    else if (r < 32) return 8'hF8 + 8'($urandom_range(0, 7));
    else if (r < 45) return 8'h00;
    else return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    reset_l  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_l = 1'b1;

    // Basic note on.
    send(8'h90); send(8'h3C); send(8'h64);
    check_val("tp1.note_ready", 32'(o_nrdy), 32'd1);
    check_val("tp1.note_on", 32'(o_non), 32'd1);
    check_val("tp1.note_number", 32'(o_num), 32'd60);
    check_val("tp1.note_velocity", 32'(o_vel), 32'd100);
    check_val("tp1.note_channel", 32'(o_ch), 32'd0);
    step(1'b0, 8'h00);
    check_val("tp1.strobe_width", 32'(o_nrdy), 32'd0);

    // Running status with note-on-zero release.
    send(8'h91); send(8'h40); send(8'h50);
    check_val("tp2.vel", 32'(o_vel), 32'd80);
    send(8'h40); send(8'h00);
    check_val("tp2.note_on_zero", 32'(o_non), 32'd0);
    check_val("tp2.note_number", 32'(o_num), 32'd64);

    // Real-time interleave inside a CC.
    send(8'hB0); send(8'hF8); send(8'h07); send(8'hFE); send(8'h7F);
    check_val("tp3.cc_ready", 32'(o_ccr), 32'd1);
    check_val("tp3.cc_value", 32'(o_ccv), 32'd127);

    // Channel filter.
    send(8'h93); send(8'h30); send(8'h40);
    check_val("tp4.filt_blocked", 32'(f_nrdy), 32'd0);
    send(8'h92); send(8'h30); send(8'h40);
    check_val("tp4.filt_pass", 32'(f_nrdy), 32'd1);
    check_val("tp4.filt_chan", 32'(f_ch), 32'd2);

    // Stray and SysEx.
    pulse_reset();
    send(8'h10); send(8'h10); send(8'h10);
    send(8'hF0); send(8'h01); send(8'hF7); send(8'h05);
    check_val("tp5.stray", 32'(o_stray), 32'd5);

    // Preemption, then reset mid-message.
    send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h00);
    check_val("tp6.note_off", 32'(o_non), 32'd0);
    send(8'h90); send(8'h3C);
    pulse_reset();
    check_val("tp6.reset_note_number", 32'(o_num), 32'd0);
    send(8'h64);
    check_val("tp6.post_reset_stray", 32'(o_stray), 32'd1);

    // Saturation of the stray counter.
    send(8'hF0);
    for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 127)));
    check_val("sat.stray", 32'(o_stray), 32'd255);

    // Randomized stream, back-to-back with occasional idle cycles and resets.
    pulse_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else if ($urandom_range(0, 9) == 0) step(1'b0, 8'($urandom_range(0, 255)));
      else send(rand_byte());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/midi_message_decoder.md
# midi_message_decoder

Converts the byte stream from the MIDI UART receiver into note and control-change events for the synthesis pipeline. Tracks status bytes, running status, real-time interleaving and channel filtering, and emits one-cycle event pulses with held payloads. Sits directly upstream of the voice pipeline: its note outputs drive the pipeline's note-change input and its ready strobe. Its CC outputs feed the parameter register block.

## Interface

Parameters:
- `OMNI`, default 1: 1 = accept all channels; 0 = accept only `CHANNEL`.
- `CHANNEL`, default 0: 4-bit receive channel, used when `OMNI` = 0.

Ports:
- `clock_50_000_000`, input, 1: system clock. One clock domain; all logic is on its rising edge.
- `reset_l`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received byte.
- `rx_valid`, input, 1: one-cycle strobe; `rx_data` is valid this cycle. Strobes may arrive back-to-back, every cycle.
- `note_on`, output, 1: 1 = note on, 0 = note off.
- `note_number`, output, 7: MIDI note number.
- `note_velocity`, output, 7: MIDI velocity.
- `note_channel`, output, 4: source channel of the note event.
- `note_ready`, output, 1: one-cycle strobe; the note payload is new this cycle.
- `cc_number`, output, 7: controller number.
- `cc_value`, output, 7: controller value.
- `cc_ready`, output, 1: one-cycle strobe; the CC payload is new this cycle.
- `stray_count`, output, 8: saturating count of discarded data bytes.

## Operation

Byte classification, applied only when `rx_valid` = 1:
- Channel status, 0x80–0xEF: latch `type` = bits 7:4 and `chan` = bits 3:0 into the running-status register, then go to DATA1.
- System common / SysEx, 0xF0–0xF7: clear running status, go to IDLE. Following data bytes are discarded.
- Real-time, 0xF8–0xFF: ignored completely. No state, register or counter changes.
- Data byte, bit 7 = 0: handled according to the current state, below.

State machine (IDLE, DATA1, DATA2):
- IDLE + data byte: discard it and increment `stray_count`. Stay in IDLE.
- DATA1 + data byte: latch `d1`.
  - Two-byte types (8, 9, A, B, E): go to DATA2.
  - One-byte types (C, D): the message is complete and ignored. Stay in DATA1, which is running status.
- DATA2 + data byte: the message is complete and `d2` is this byte. Return to DATA1, so running status is retained.
- A status byte in any state preempts an unfinished message. The partial data is dropped and is not counted as stray.

Emission when a message completes and its channel passes the filter (`OMNI` = 1, or `chan` = `CHANNEL`):
- Type 9 with `d2` ≠ 0: `note_on` = 1, `note_number` = `d1`, `note_velocity` = `d2`, `note_channel` = `chan`. Pulse `note_ready`.
- Type 9 with `d2` = 0, or type 8: same payload with `note_on` = 0. `note_velocity` = `d2`, the release velocity, which is 0 for the note-on-zero case.
- Type B: `cc_number` = `d1`, `cc_value` = `d2`. Pulse `cc_ready`.
- Types A and E: parsed fully, so running status advances, but nothing is emitted.
- Filtered-out channel: parsed fully, nothing is emitted, and payload registers are unchanged.

Payload and counter rules:
- Payload registers hold their value between events and change only in the cycle their strobe asserts.
- `stray_count` saturates at 255. It is cleared only by reset.

## Timing

- Reset (async assert) sets:
  - State to IDLE; running status invalid.
  - All payload outputs, `note_on`, `note_ready`, `cc_ready` and `stray_count` to 0.
- Reset deassertion: the first `rx_valid` byte sampled after the release edge is processed normally.
- Latency: the strobe asserts in the cycle after the `rx_valid` cycle of the completing byte, exactly one cycle later. All outputs are registered.
- Strobe width: each strobe is exactly 1 cycle. No backpressure; downstream must sample on the strobe.
- Back-to-back input: a message completing on every second byte produces a strobe every second cycle. No byte is lost at full input rate.
- `note_ready` and `cc_ready` never assert in the same cycle, since at most one message completes per byte.
- Reset asserted mid-message: the partial message is discarded and no strobe is issued.

## Test plan

- Input 0x90, 0x3C, 0x64 on consecutive cycles -> one cycle after the third byte: `note_ready` = 1, `note_on` = 1, `note_number` = 60, `note_velocity` = 100, `note_channel` = 0.
- Running status: 0x91, 0x40, 0x50, then 0x40, 0x00 -> two `note_ready` pulses. The first has `note_on` = 1, velocity 80, channel 1. The second has `note_on` = 0, note 64.
- Real-time interleave: 0xB0, 0xF8, 0x07, 0xFE, 0x7F -> a single `cc_ready` with `cc_number` = 7, `cc_value` = 127. No other strobes.
- Filter with `OMNI` = 0, `CHANNEL` = 2: 0x93, 0x30, 0x40, then 0x92, 0x30, 0x40 -> only the second message strobes (`note_channel` = 2). Payloads are unchanged after the first message.
- Stray and SysEx: after reset, 0x10 ×3, then 0xF0, 0x01, 0xF7, 0x05 -> `stray_count` = 5 (3 + the SysEx payload byte 0x01 + the trailing 0x05). No strobes.
- Preemption and reset: 0x90, 0x3C, 0x80, 0x3C, 0x00 -> one strobe, `note_on` = 0. Then 0x90, 0x3C with `reset_l` pulsed low -> all outputs 0. A following 0x64 counts as stray and produces no strobe.
